// File: rtl/i2c_state_ctrl.sv
// Transaction sequencer for the I2C EEPROM master: produces bus state code and per-state tick count.
// Optional NACK retry on chip-address NACK is enabled by defining I2C_NACK_RETRY_EN.
module i2c_state_ctrl #(
  parameter int unsigned START_TICKS = 40,
  parameter int unsigned BYTE_TICKS  = 225,
  parameter int unsigned STOP_TICKS  = 40,
  parameter int unsigned ACK_TICK    = 221
) (
  input  logic       i_clk10MHz,
  input  logic       i_RST_n,
  input  logic       i_Req,
  input  logic       i_R_W,
  input  logic [7:0] i_Data_Num,
  input  logic       i_Num_Remain,
  input  logic       i_SDA_In,
  output logic [2:0] o_Current_State,
  output logic [7:0] o_Clock_Timer,
  output logic       o_Read_Setting_Flag,
  output logic       o_Busy,
  output logic       o_Byte_Done,
  output logic       o_Done,
  output logic       o_Nack_Err
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StChipAddr = 3'd2,
    StRegAddr  = 3'd3,
    StDataSend = 3'd4,
    StDataRcv  = 3'd5,
    StStop     = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       rw_q, rw_d;
  logic       flag_q, flag_d;
  logic       nack_err_q, nack_err_d;
  logic       nack_q, nack_d;
  logic       done_q, done_d;

  logic [7:0] tick_last;
  logic       expiry;
  logic       ack_slot;
  logic       accept;
  logic       nack_now;
  logic       nack_hit;
  logic       retry_take;
  logic       retry_go;

  always_comb begin
    tick_last = 8'(BYTE_TICKS - 1);
    case (state_q)
      StStart: tick_last = 8'(START_TICKS - 1);
      StStop:  tick_last = 8'(STOP_TICKS - 1);
      default: ;
    endcase
  end

  assign expiry   = (state_q != StIdle) && (timer_q == tick_last);
  assign ack_slot = (state_q == StChipAddr) || (state_q == StRegAddr) || (state_q == StDataSend);
  assign accept   = (state_q == StIdle) && i_Req && (i_Data_Num != 8'd0);
  assign nack_now = ack_slot && (timer_q == 8'(ACK_TICK)) && i_SDA_In;
  assign nack_hit = ack_slot && (nack_q || nack_now);

`ifdef I2C_NACK_RETRY_EN
  localparam int unsigned RETRY_MAX = 3;

  logic [1:0] retry_cnt_q, retry_cnt_d;
  logic       retry_pend_q, retry_pend_d;

  // Chip-address NACK means the EEPROM is still busy; loop Stop->Start instead of failing.
  assign retry_take = (state_q == StChipAddr) && nack_hit && (32'(retry_cnt_q) < RETRY_MAX);
  assign retry_go   = retry_pend_q;

  always_comb begin
    retry_cnt_d  = retry_cnt_q;
    retry_pend_d = retry_pend_q;
    if (accept) begin
      retry_cnt_d  = '0;
      retry_pend_d = 1'b0;
    end else if (expiry && retry_take) begin
      retry_pend_d = 1'b1;
    end else if (expiry && (state_q == StStop) && retry_pend_q) begin
      retry_pend_d = 1'b0;
      retry_cnt_d  = retry_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge i_clk10MHz or negedge i_RST_n) begin
    if (!i_RST_n) begin
      retry_cnt_q  <= '0;
      retry_pend_q <= 1'b0;
    end else begin
      retry_cnt_q  <= retry_cnt_d;
      retry_pend_q <= retry_pend_d;
    end
  end
`else
  assign retry_take = 1'b0;
  assign retry_go   = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk10MHz or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) state_d = StStart;
      end
      StStart: begin
        if (expiry) state_d = StChipAddr;
      end
      StChipAddr: begin
        if (expiry) begin
          if (nack_hit)              state_d = StStop;
          else if (!rw_q || !flag_q) state_d = StRegAddr;
          else                       state_d = StDataRcv;
        end
      end
      StRegAddr: begin
        if (expiry) begin
          if (nack_hit)  state_d = StStop;
          else if (rw_q) state_d = StStart;
          else           state_d = StDataSend;
        end
      end
      StDataSend: begin
        if (expiry) begin
          if (nack_hit || !i_Num_Remain) state_d = StStop;
        end
      end
      StDataRcv: begin
        if (expiry && !i_Num_Remain) state_d = StStop;
      end
      StStop: begin
        if (expiry) state_d = retry_go ? StStart : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Tick counter and transaction context
  always_comb begin
    timer_d    = '0;
    rw_d       = rw_q;
    flag_d     = flag_q;
    nack_err_d = nack_err_q;
    nack_d     = (nack_q || nack_now) && !expiry;
    done_d     = (state_q == StStop) && expiry && !retry_go;

    if ((state_q != StIdle) && !expiry) timer_d = timer_q + 8'd1;

    if (accept) begin
      rw_d       = i_R_W;
      flag_d     = 1'b0;
      nack_err_d = 1'b0;
    end

    if ((state_q == StRegAddr) && expiry && rw_q && !nack_hit) flag_d = 1'b1;
    if ((state_q == StStop) && expiry && retry_go) flag_d = 1'b0;
    if (expiry && nack_hit && !retry_take) nack_err_d = 1'b1;
  end

  always_ff @(posedge i_clk10MHz or negedge i_RST_n) begin
    if (!i_RST_n) begin
      timer_q    <= '0;
      rw_q       <= 1'b0;
      flag_q     <= 1'b0;
      nack_err_q <= 1'b0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      rw_q       <= rw_d;
      flag_q     <= flag_d;
      nack_err_q <= nack_err_d;
      nack_q     <= nack_d;
      done_q     <= done_d;
    end
  end

  // Outputs
  always_comb begin
    o_Current_State     = state_q;
    o_Clock_Timer       = timer_q;
    o_Read_Setting_Flag = flag_q;
    o_Busy              = (state_q != StIdle);
    o_Byte_Done         = expiry && ((state_q == StDataSend) || (state_q == StDataRcv));
    o_Done              = done_q;
    o_Nack_Err          = nack_err_q;
  end

endmodule

// File: tb/tb_i2c_state_ctrl.sv
// Directed bench for i2c_state_ctrl: records state segments per transaction against hand-computed
// sequences, lengths, pulse counts and latencies.
module tb_i2c_state_ctrl;

  logic       clk10MHz = 1'b0;
  logic       rst_n    = 1'b1;
  logic       req      = 1'b0;
  logic       r_w      = 1'b0;
  logic [7:0] data_num = 8'd0;
  logic       num_remain = 1'b1;
  logic       sda      = 1'b0;

  logic [2:0] cur_state;
  logic [7:0] clock_timer;
  logic       read_flag, busy, byte_done, done, nack_err;

  i2c_state_ctrl dut (
    .i_clk10MHz         (clk10MHz),
    .i_RST_n            (rst_n),
    .i_Req              (req),
    .i_R_W              (r_w),
    .i_Data_Num         (data_num),
    .i_Num_Remain       (num_remain),
    .i_SDA_In           (sda),
    .o_Current_State    (cur_state),
    .o_Clock_Timer      (clock_timer),
    .o_Read_Setting_Flag(read_flag),
    .o_Busy             (busy),
    .o_Byte_Done        (byte_done),
    .o_Done             (done),
    .o_Nack_Err         (nack_err)
  );

  always #50 clk10MHz = ~clk10MHz;

  int total = 0;
  int bad   = 0;

  int seg_state[$];
  int seg_len[$];
  int seg_flag[$];
  int exp_s[$];
  int exp_l[$];

  int cyc, byte_cnt, done_cnt, done_at, bytes_seen, chip_pass, slave_mode, num_cfg;
  logic       nack_at0, busy_at0;
  logic [7:0] tm0, tm39, tm40;
  logic       found;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] outs_vec();
    return {cur_state, clock_timer, read_flag, busy, byte_done, done, nack_err};
  endfunction

  task automatic sample();
    @(negedge clk10MHz);
    if (seg_state.size() == 0 || seg_state[seg_state.size()-1] != int'(cur_state)) begin
      seg_state.push_back(int'(cur_state));
      seg_len.push_back(1);
      seg_flag.push_back(int'(read_flag));
      if (cur_state == 3'd2) chip_pass++;
    end else begin
      seg_len[seg_len.size()-1] = seg_len[seg_len.size()-1] + 1;
    end
    if (byte_done) begin
      byte_cnt++;
      bytes_seen++;
    end
    if (done) begin
      done_cnt++;
      if (done_at < 0) done_at = cyc;
    end
    if (cyc == 0) begin
      nack_at0 = nack_err;
      busy_at0 = busy;
      tm0      = clock_timer;
    end
    if (cyc == 39) tm39 = clock_timer;
    if (cyc == 40) tm40 = clock_timer;
  endtask

  // Slave/datapath model: answers at the ACK tick according to slave_mode.
  task automatic drive_slave();
    sda = 1'b0;
    if (clock_timer == 8'd221) begin
      case (slave_mode)
        1: sda = (cur_state == 3'd2);
        2: sda = (cur_state == 3'd2) && (chip_pass == 1);
        3: sda = (cur_state == 3'd4);
        4: sda = (cur_state == 3'd5);
        default: sda = 1'b0;
      endcase
    end
    num_remain = (bytes_seen < num_cfg);
  endtask

  task automatic start_txn(input logic rw, input int num, input int mode);
    seg_state.delete();
    seg_len.delete();
    seg_flag.delete();
    byte_cnt = 0; done_cnt = 0; done_at = -1; bytes_seen = 0; chip_pass = 0;
    slave_mode = mode; num_cfg = num; cyc = 0;
    req = 1'b1; r_w = rw; data_num = 8'(num); num_remain = 1'b1; sda = 1'b0;
  endtask

  task automatic run_txn(input logic rw, input int num, input int mode, input int inj);
    start_txn(rw, num, mode);
    while (done_cnt == 0 && cyc < 3000) begin
      sample();
      if (cyc == inj) begin
        req = 1'b1; r_w = ~rw; data_num = 8'd5;
      end else begin
        req = 1'b0;
      end
      drive_slave();
      cyc++;
    end
    check_val("done_seen", done_cnt, 1);
  endtask

  task automatic check_seq(input string name);
    check_val($sformatf("%s.nseg", name), seg_state.size(), exp_s.size());
    for (int i = 0; i < exp_s.size(); i++) begin
      if (i < seg_state.size()) begin
        check_val($sformatf("%s.st%0d", name, i), seg_state[i], exp_s[i]);
        if (i < exp_l.size()) check_val($sformatf("%s.len%0d", name, i), seg_len[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    #5 rst_n = 1'b0;
    #1 check_val("reset.outs", outs_vec(), 0);
    repeat (2) @(negedge clk10MHz);
    check_val("reset.hold", outs_vec(), 0);
    rst_n = 1'b1;

    // NACK in Data_Send (Num=2): ends after the first slot
    run_txn(1'b0, 2, 3, -1);
    exp_s = '{1, 2, 3, 4, 6, 0};
    exp_l = '{40, 225, 225, 225, 40};
    check_seq("dsnack");
    check_val("dsnack.bytes", byte_cnt, 1);
    check_val("dsnack.done_at", done_at, 755);
    check_val("dsnack.err", nack_err, 1);

    // Req with Num=0 in Idle is ignored; error stays
    req = 1'b1; r_w = 1'b1; data_num = 8'd0;
    @(negedge clk10MHz);
    req = 1'b0;
    @(negedge clk10MHz);
    check_val("num0.state", cur_state, 0);
    check_val("num0.err_kept", nack_err, 1);

    // Single-byte write, plus a request on the Stop->Idle edge
    run_txn(1'b0, 1, 0, 754);
    check_seq("wr1");
    check_val("wr1.err_cleared", nack_at0, 0);
    check_val("wr1.busy0", busy_at0, 1);
    check_val("wr1.tm0", tm0, 0);
    check_val("wr1.tm39", tm39, 39);
    check_val("wr1.tm40", tm40, 0);
    check_val("wr1.bytes", byte_cnt, 1);
    check_val("wr1.done_at", done_at, 755);
    check_val("wr1.busy_end", busy, 0);
    check_val("wr1.flag", seg_flag[3], 0);
    @(negedge clk10MHz);
    check_val("wr1.edge_req_ignored", cur_state, 0);

    // Random read, 2 bytes; SDA high at tick 221 of Data_Rcv must not count as NACK
    run_txn(1'b1, 2, 4, -1);
    exp_s = '{1, 2, 3, 1, 2, 5, 6, 0};
    exp_l = '{40, 225, 225, 40, 225, 450, 40};
    check_seq("rd2");
    check_val("rd2.flag_first", seg_flag[0], 0);
    check_val("rd2.flag_reg", seg_flag[2], 0);
    check_val("rd2.flag_restart", seg_flag[3], 1);
    check_val("rd2.flag_rcv", seg_flag[5], 1);
    check_val("rd2.bytes", byte_cnt, 2);
    check_val("rd2.done_at", done_at, 1245);
    check_val("rd2.err", nack_err, 0);

    // Num=0 request must not clear the read flag
    req = 1'b1; r_w = 1'b0; data_num = 8'd0;
    @(negedge clk10MHz);
    req = 1'b0;
    @(negedge clk10MHz);
    check_val("num0b.state", cur_state, 0);
    check_val("num0b.flag_kept", read_flag, 1);

    // Read request while busy in Chip_Addr_Send must not alter the write
    run_txn(1'b0, 1, 0, 100);
    exp_s = '{1, 2, 3, 4, 6, 0};
    exp_l = '{40, 225, 225, 225, 40};
    check_seq("busyreq");
    check_val("busyreq.flag_cleared", seg_flag[0], 0);
    check_val("busyreq.done_at", done_at, 755);

`ifdef I2C_NACK_RETRY_EN
    run_txn(1'b0, 1, 1, -1);
    exp_s = '{1, 2, 6, 1, 2, 6, 1, 2, 6, 1, 2, 6, 0};
    exp_l = '{40, 225, 40, 40, 225, 40, 40, 225, 40, 40, 225, 40};
    check_seq("retry_all");
    check_val("retry_all.done_at", done_at, 1220);
    check_val("retry_all.err", nack_err, 1);

    run_txn(1'b0, 1, 2, -1);
    exp_s = '{1, 2, 6, 1, 2, 3, 4, 6, 0};
    exp_l = '{40, 225, 40, 40, 225, 225, 225, 40};
    check_seq("retry_ok");
    check_val("retry_ok.done_at", done_at, 1060);
    check_val("retry_ok.err", nack_err, 0);
`else
    run_txn(1'b0, 1, 1, -1);
    exp_s = '{1, 2, 6, 0};
    exp_l = '{40, 225, 40};
    check_seq("chipnack");
    check_val("chipnack.bytes", byte_cnt, 0);
    check_val("chipnack.done_at", done_at, 305);
    check_val("chipnack.err", nack_err, 1);
`endif

    // Reset at tick 100 of Data_Send
    start_txn(1'b0, 1, 0);
    found = 1'b0;
    while (!found && cyc < 2000) begin
      sample();
      req = 1'b0;
      drive_slave();
      cyc++;
      if (cur_state == 3'd4 && clock_timer == 8'd100) found = 1'b1;
    end
    check_val("rst.reach", found, 1);
    #10 rst_n = 1'b0;
    #1 check_val("rst.immediate", outs_vec(), 0);
    req = 1'b1; data_num = 8'd1;
    repeat (3) begin
      @(negedge clk10MHz);
      check_val("rst.held", outs_vec(), 0);
    end
    rst_n = 1'b1;
    req = 1'b0;
    @(negedge clk10MHz);
    check_val("rst.after", {cur_state, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
